// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an approximate multiplier under test.
// Streams (a, b, y) samples and accumulates wrong/correct counts, max ED and sum of ED.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, clear         run start pulse (target latched), sync clear (wins over start)
//   sample_target        samples per run
//   in_valid/in_ready    sample handshake; in_a, in_b operands, in_y approx product
//   busy, done           run in progress / statistics final
//   cnt_wrong, cnt_correct, max_ed, sum_ed   run statistics
module approx_mult_err_monitor #(
  parameter int OP_W  = 32,
  parameter int CNT_W = 32,
  parameter int SUM_W = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  sample_target,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [2*OP_W-1:0] in_y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_wrong,
  output logic [CNT_W-1:0]  cnt_correct,
  output logic [2*OP_W-1:0] max_ed,
  output logic [SUM_W-1:0]  sum_ed
);

  localparam int PW = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] acc_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic             s1_v_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [PW-1:0]    y_q;

  logic             s2_v_q;
  logic             eq_q;
  logic [PW-1:0]    ed_q;

  logic [CNT_W-1:0] wrong_q;
  logic [CNT_W-1:0] correct_q;
  logic [PW-1:0]    max_q;
  logic [SUM_W-1:0] sum_q;

  logic             xfer;
  logic [PW-1:0]    exact_d;
  logic [PW-1:0]    ed_d;
  logic             eq_d;
  logic [CNT_W-1:0] acc_d;
  logic             last_d;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_d;
  logic [CNT_W-1:0] wrong_d;
  logic [CNT_W-1:0] correct_d;
  logic [PW-1:0]    max_d;

  always_comb begin
    xfer    = in_valid & in_ready_q;
    exact_d = {{OP_W{1'b0}}, a_q} * {{OP_W{1'b0}}, b_q};
    eq_d    = (exact_d == y_q);
    ed_d    = (exact_d >= y_q) ? exact_d - y_q : y_q - exact_d;
    acc_d   = acc_q + CNT_W'(1);
    last_d  = (acc_d == target_q);
    // one extra bit catches the carry out for saturation
    sum_ext = {1'b0, sum_q} + {{(SUM_W+1-PW){1'b0}}, ed_q};
    sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    wrong_d   = (&wrong_q)   ? wrong_q   : wrong_q + CNT_W'(1);
    correct_d = (&correct_q) ? correct_q : correct_q + CNT_W'(1);
    max_d     = (ed_q > max_q) ? ed_q : max_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      s2_v_q     <= 1'b0;
      eq_q       <= 1'b0;
      ed_q       <= '0;
      wrong_q    <= '0;
      correct_q  <= '0;
      max_q      <= '0;
      sum_q      <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      wrong_q    <= '0;
      correct_q  <= '0;
      max_q      <= '0;
      sum_q      <= '0;
    end else begin
      s1_v_q <= xfer;
      if (xfer) begin
        a_q <= in_a;
        b_q <= in_b;
        y_q <= in_y;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        ed_q <= ed_d;
        eq_q <= eq_d;
      end
      if (s2_v_q) begin
        if (eq_q) correct_q <= correct_d;
        else      wrong_q   <= wrong_d;
        max_q <= max_d;
        sum_q <= sum_d;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            target_q  <= sample_target;
            acc_q     <= '0;
            wrong_q   <= '0;
            correct_q <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            if (sample_target != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            acc_q <= acc_d;
            if (last_d) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_v_q && !s2_v_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt_wrong   = wrong_q;
  assign cnt_correct = correct_q;
  assign max_ed      = max_q;
  assign sum_ed      = sum_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor.
// Linear stimulus sequence with hand-computed expected statistics.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] sample_target = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [63:0] in_y = '0;
  logic        busy;
  logic        done;
  logic [31:0] cnt_wrong;
  logic [31:0] cnt_correct;
  logic [63:0] max_ed;
  logic [95:0] sum_ed;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfers = 0;
  int cs = 0;

  approx_mult_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .sample_target(sample_target),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .busy(busy), .done(done),
    .cnt_wrong(cnt_wrong), .cnt_correct(cnt_correct),
    .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clk = ~clk;

  task automatic step();
    if (in_valid && in_ready) xfers++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [63:0] y);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_y = y;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic kick(input logic [31:0] t);
    start = 1'b1;
    sample_target = t;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk("wait_done", done, 1'b1);
  endtask

  task automatic chk_stats(input string tag,
                           input logic [31:0] w,
                           input logic [31:0] c,
                           input logic [63:0] m,
                           input logic [95:0] s);
    chk({tag, "_wrong"}, cnt_wrong, w);
    chk({tag, "_correct"}, cnt_correct, c);
    chk({tag, "_max"}, max_ed, m);
    chk({tag, "_sum"}, sum_ed, s);
  endtask

  initial begin
    // reset
    step();
    step();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk_stats("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // run 1: all exact, minimum latency 7 cycles
    kick(4);
    cs = cyc;
    chk("r1_busy", busy, 1'b1);
    chk("r1_ready", in_ready, 1'b1);
    send(3, 5, 15);
    send(0, 7, 0);
    send(255, 255, 65025);
    send(1, 1, 1);
    chk("r1_ready_drop", in_ready, 1'b0);
    chk("r1_busy_drain", busy, 1'b1);
    wait_done();
    chk("r1_latency", cyc - cs, 7);
    chk("r1_busy_end", busy, 1'b0);
    chk_stats("r1", 0, 4, 0, 0);

    // run 2: two errors of distance 4, one above and one below
    kick(3);
    send(10, 10, 96);
    send(10, 10, 104);
    send(2, 3, 6);
    wait_done();
    chk_stats("r2", 2, 1, 4, 8);

    // run 3: full-width product against y=0
    kick(2);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    send(1, 1, 1);
    wait_done();
    chk_stats("r3", 1, 1, 64'hFFFFFFFE00000001,
              96'h0000_0000_FFFF_FFFE_0000_0001);

    // run 4: zero target completes immediately
    kick(0);
    chk("r4_done", done, 1'b1);
    chk("r4_busy", busy, 1'b0);
    chk("r4_ready0", in_ready, 1'b0);
    chk_stats("r4", 0, 0, 0, 0);
    step();
    chk("r4_ready1", in_ready, 1'b0);
    chk("r4_done_hold", done, 1'b1);

    // run 5: gaps between samples, then extra beats refused
    xfers = 0;
    kick(5);
    for (int i = 1; i <= 5; i++) begin
      send(i, 3, 64'(3 * i + 1));
      if (i < 5) step();
    end
    chk("r5_ready_drop", in_ready, 1'b0);
    in_valid = 1'b1;
    in_a = 100;
    in_b = 100;
    in_y = 0;
    wait_done();
    step();
    step();
    in_valid = 1'b0;
    chk("r5_xfers", xfers, 5);
    chk_stats("r5", 5, 0, 1, 5);

    // run 6: clear mid-run
    kick(5);
    send(4, 4, 0);
    send(2, 2, 7);
    step();
    step();
    step();
    chk_stats("r6_pre", 2, 0, 16, 19);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("r6_busy", busy, 1'b0);
    chk("r6_done", done, 1'b0);
    chk("r6_ready", in_ready, 1'b0);
    chk_stats("r6", 0, 0, 0, 0);
    step();
    step();
    chk("r6_idle_done", done, 1'b0);

    // run 7: async reset mid-run
    kick(5);
    send(4, 4, 0);
    send(2, 2, 7);
    step();
    step();
    step();
    chk("r7_pre_wrong", cnt_wrong, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r7_busy", busy, 1'b0);
    chk("r7_ready", in_ready, 1'b0);
    chk("r7_done", done, 1'b0);
    chk_stats("r7", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("r7_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Hardware counterpart of the multiplier bench checker: consumes a stream of (a, b, y) samples from an approximate multiplier under test.
- Computes the exact product internally and accumulates error statistics: wrong count, correct count, max error distance (ED) and sum of ED.
- Sits beside approx_32x32 in on-chip characterization builds, so error metrics come from hardware rather than simulation CSV dumps.

Parameters:
OP_W, 32, operand width; product width is 2*OP_W
CNT_W, 32, width of sample_target and the wrong/correct counters
SUM_W, 96, width of the ED sum accumulator

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a run of sample_target samples
clear  in  1  synchronous clear of all state and statistics
sample_target  in  CNT_W  number of samples for the run, sampled on start
in_valid  in  1  sample valid
in_ready  out  1  monitor accepts a sample this cycle
in_a  in  OP_W  operand a
in_b  in  OP_W  operand b
in_y  in  2*OP_W  approximate product under test
busy  out  1  high in RUN or DRAIN
done  out  1  run complete; statistics final
cnt_wrong  out  CNT_W  samples with y != a*b
cnt_correct  out  CNT_W  samples with y == a*b
max_ed  out  2*OP_W  maximum |a*b - y| seen in the run
sum_ed  out  SUM_W  sum of |a*b - y| over the run

Behaviour:
- Reset (rst_n=0, async): state IDLE; pipeline valids 0; in_ready=0, busy=0, done=0; all statistics 0.
- Transfer occurs on a rising edge with in_valid & in_ready.
- FSM states:
  - IDLE: start with target>0 -> RUN, latch target, zero stats and the accepted counter. start with target=0 -> DONE with stats zero.
  - RUN: in_ready=1 while accepted<target. On the transfer that makes accepted==target -> DRAIN, and in_ready drops the next cycle.
  - DRAIN: in_ready=0; wait until both pipeline stages are empty -> DONE.
  - DONE: done=1, stats held; start -> new run (same rules as IDLE).
- start in RUN/DRAIN is ignored.
- clear has priority over start: any state -> IDLE, stats zero, pipeline valids zero, accepted counter zero; takes effect at the next edge.
- Pipeline, 3 stages; sample transferred at edge E0:
  - E0: register a, b, y.
  - E1: register exact = a*b (2*OP_W, unsigned) and ed = |exact - y|, compared as unsigned 2*OP_W values, plus an eq flag.
  - E2: update statistics. After E2: cnt_wrong or cnt_correct incremented; max_ed = max(max_ed, ed); sum_ed += ed (zero-extended).
- Latency is 3 edges from transfer to visible statistics.
- done asserts 1 cycle after the last sample's E2 (DRAIN-to-DONE edge).
- No backpressure inside the pipeline: stages advance every cycle, and bubbles carry valid=0.
- Saturation: cnt_wrong, cnt_correct and sum_ed saturate at all-ones; max_ed cannot overflow.
- Invariant at done: cnt_wrong + cnt_correct == sample_target (when not saturated).
- in_valid gaps during RUN: pipeline fills with bubbles, statistics unaffected.

Test Plan:
- start, target=4; samples (3,5,15), (0,7,0), (255,255,65025), (1,1,1) -> done after 7 cycles min, cnt_correct=4, cnt_wrong=0, max_ed=0, sum_ed=0.
- target=3; samples (10,10,96), (10,10,104), (2,3,6) -> cnt_wrong=2, cnt_correct=1, max_ed=4, sum_ed=8.
- target=2; samples (32'hFFFFFFFF, 32'hFFFFFFFF, 0), (1,1,1) -> max_ed=64'hFFFFFFFE00000001, sum_ed equal to it, cnt_wrong=1.
- target=0 start -> done=1 the next cycle, all stats 0, in_ready never high.
- target=5 with in_valid low on alternate cycles -> exactly 5 transfers; in_ready low after the 5th; extra in_valid beats are not accepted and stats are unchanged.
- clear asserted after 2 of 5 samples -> IDLE, stats 0, done=0. Repeat with rst_n pulsed low mid-run -> outputs go to 0 immediately, without waiting for a clock edge.
